// File: rtl/bubble_access_sequencer_if.sv
// Host-side command, read-data and write-data handshake of the bubble access sequencer.
interface bubble_access_sequencer_if #(
    parameter int AW = 12
) ();
    logic          i_CMD_VALID;
    logic          o_CMD_READY;
    logic [1:0]    i_CMD;
    logic [AW-1:0] i_PAGE;
    logic          o_RBIT;
    logic          o_RBIT_VALID;
    logic          i_WBIT;
    logic          i_WBIT_VALID;
    logic          o_WBIT_READY;
    logic [AW-1:0] o_POS;
    logic          o_BUSY;
    logic          o_DONE;
    logic          o_ERR;

    modport slave (
        input  i_CMD_VALID, i_CMD, i_PAGE, i_WBIT, i_WBIT_VALID,
        output o_CMD_READY, o_RBIT, o_RBIT_VALID, o_WBIT_READY, o_POS, o_BUSY, o_DONE, o_ERR
    );

    modport master (
        output i_CMD_VALID, i_CMD, i_PAGE, i_WBIT, i_WBIT_VALID,
        input  o_CMD_READY, o_RBIT, o_RBIT_VALID, o_WBIT_READY, o_POS, o_BUSY, o_DONE, o_ERR
    );
endinterface

// File: rtl/bubble_access_sequencer.sv
// SEEK/READ/WRITE page sequencer for the MB14506 bubble timing generator: tracks the
// minor-loop position and steps the generator controls one rotation at a time.
module bubble_access_sequencer #(
    parameter int LOOP_LEN   = 2053,
    parameter int AW         = 12,
    parameter int PAGE_BITS  = 64,
    parameter int DETECT_LAT = 4,
    parameter int BSS_CYCLES = 16
) (
    input  logic i_EMUCLK,
    input  logic i_RST,
    input  logic i_ROT_TICK,
    input  logic i_SENSE,
    output logic o_BSS_n,
    output logic o_BSEN_n,
    output logic o_REPEN_n,
    output logic o_SWAPEN_n,
    output logic o_WRDATA_n,
    bubble_access_sequencer_if.slave bus
);
    localparam int CW = $clog2(PAGE_BITS + DETECT_LAT + BSS_CYCLES + 2);
    localparam logic [AW-1:0] LAST_POS  = AW'(LOOP_LEN - 1);
    localparam logic [CW-1:0] BSS_END   = CW'(BSS_CYCLES - 1);
    localparam logic [CW-1:0] GEN_END   = CW'(PAGE_BITS);
    localparam logic [CW-1:0] CAP_FIRST = CW'(DETECT_LAT);
    localparam logic [CW-1:0] CAP_LAST  = CW'(PAGE_BITS + DETECT_LAT - 1);
    localparam logic [1:0] CMD_SEEK  = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_WRITE = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_BSS, S_WAIT0, S_GEN, S_ALIGN, S_REPL, S_DRAIN, S_SWAP, S_STOP
    } state_t;

    state_t        state_q;
    logic [AW-1:0] pos_q, pos_d, tgt_q;
    logic [1:0]    cmd_q;
    logic [CW-1:0] cnt_q, cnt_inc;
    logic          bss_n_q, bsen_n_q, repen_n_q, swapen_n_q, wrdata_n_q;
    logic          rbit_q, rvalid_q, done_q, err_q, cmd_err_q;
    logic          hold_full_q, hold_bit_q;
    logic          shift, at_tgt, wready, wload;

    // The rotation-0 tick in WAIT0 never advances the loop; every later shifting tick does.
    always_comb begin
        shift   = i_ROT_TICK && !bsen_n_q && (state_q != S_WAIT0);
        pos_d   = pos_q;
        if (shift) pos_d = (pos_q == LAST_POS) ? '0 : pos_q + AW'(1);
        at_tgt  = (pos_d == tgt_q);
        cnt_inc = cnt_q + CW'(1);
        wready  = (cmd_q == CMD_WRITE) && !hold_full_q &&
                  (state_q == S_BSS || state_q == S_WAIT0 || state_q == S_GEN);
        wload   = bus.i_WBIT_VALID && wready;
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state_q     <= S_IDLE;
            pos_q       <= '0;
            tgt_q       <= '0;
            cmd_q       <= 2'b00;
            cnt_q       <= '0;
            bss_n_q     <= 1'b1;
            bsen_n_q    <= 1'b1;
            repen_n_q   <= 1'b1;
            swapen_n_q  <= 1'b1;
            wrdata_n_q  <= 1'b1;
            rbit_q      <= 1'b0;
            rvalid_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_err_q   <= 1'b0;
            hold_full_q <= 1'b0;
            hold_bit_q  <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            pos_q    <= pos_d;
            if (wload) begin
                hold_full_q <= 1'b1;
                hold_bit_q  <= bus.i_WBIT;
            end
            // Per-rotation enables fall back to inactive on each tick unless re-armed below.
            if (i_ROT_TICK) begin
                repen_n_q  <= 1'b1;
                swapen_n_q <= 1'b1;
                wrdata_n_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: if (bus.i_CMD_VALID) begin
                    if (bus.i_CMD == 2'b00 || bus.i_PAGE > LAST_POS) begin
                        err_q <= 1'b1;
                    end else if (bus.i_CMD == CMD_SEEK && bus.i_PAGE == pos_q) begin
                        done_q <= 1'b1;
                    end else begin
                        state_q     <= S_BSS;
                        cmd_q       <= bus.i_CMD;
                        tgt_q       <= bus.i_PAGE;
                        cnt_q       <= '0;
                        bss_n_q     <= 1'b0;
                        cmd_err_q   <= 1'b0;
                        hold_full_q <= 1'b0;
                    end
                end
                S_BSS: if (cnt_q == BSS_END) begin
                    bss_n_q  <= 1'b1;
                    bsen_n_q <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= S_WAIT0;
                end else begin
                    cnt_q <= cnt_inc;
                end
                S_WAIT0, S_GEN: if (i_ROT_TICK) begin
                    if (state_q == S_WAIT0 && cmd_q != CMD_WRITE) begin
                        if (!at_tgt)               state_q <= S_ALIGN;
                        else if (cmd_q == CMD_READ) begin
                            repen_n_q <= 1'b0;
                            state_q   <= S_REPL;
                        end else begin
                            state_q  <= S_STOP;
                            bsen_n_q <= 1'b1;
                        end
                    end else if (cnt_q == GEN_END) begin
                        if (at_tgt) begin
                            swapen_n_q <= 1'b0;
                            state_q    <= S_SWAP;
                        end else begin
                            state_q <= S_ALIGN;
                        end
                    end else if (hold_full_q) begin
                        // A bit arriving on the consuming edge refills the register.
                        wrdata_n_q  <= ~hold_bit_q;
                        hold_full_q <= wload;
                        cnt_q       <= cnt_inc;
                        state_q     <= S_GEN;
                    end else begin
                        err_q     <= 1'b1;
                        cmd_err_q <= 1'b1;
                        state_q   <= S_STOP;
                        bsen_n_q  <= 1'b1;
                        cnt_q     <= '0;
                    end
                end
                S_ALIGN: if (i_ROT_TICK && at_tgt) begin
                    cnt_q <= '0;
                    case (cmd_q)
                        CMD_READ: begin
                            repen_n_q <= 1'b0;
                            state_q   <= S_REPL;
                        end
                        CMD_WRITE: begin
                            swapen_n_q <= 1'b0;
                            state_q    <= S_SWAP;
                        end
                        default: begin
                            state_q  <= S_STOP;
                            bsen_n_q <= 1'b1;
                        end
                    endcase
                end
                S_REPL, S_DRAIN: if (i_ROT_TICK) begin
                    cnt_q <= cnt_inc;
                    if (cnt_inc >= CAP_FIRST) begin
                        rbit_q   <= i_SENSE;
                        rvalid_q <= 1'b1;
                    end
                    if (cnt_inc == CAP_LAST) begin
                        state_q  <= S_STOP;
                        bsen_n_q <= 1'b1;
                        cnt_q    <= '0;
                    end else if (state_q == S_REPL) begin
                        if (cnt_inc == GEN_END) state_q   <= S_DRAIN;
                        else                    repen_n_q <= 1'b0;
                    end
                end
                S_SWAP: if (i_ROT_TICK) begin
                    state_q  <= S_STOP;
                    bsen_n_q <= 1'b1;
                    cnt_q    <= '0;
                end
                S_STOP: if (i_ROT_TICK) begin
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_IDLE;
                        done_q  <= !cmd_err_q;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_BSS_n          = bss_n_q;
    assign o_BSEN_n         = bsen_n_q;
    assign o_REPEN_n        = repen_n_q;
    assign o_SWAPEN_n       = swapen_n_q;
    assign o_WRDATA_n       = wrdata_n_q;
    assign bus.o_CMD_READY  = (state_q == S_IDLE);
    assign bus.o_BUSY       = (state_q != S_IDLE);
    assign bus.o_RBIT       = rbit_q;
    assign bus.o_RBIT_VALID = rvalid_q;
    assign bus.o_WBIT_READY = wready;
    assign bus.o_POS        = pos_q;
    assign bus.o_DONE       = done_q;
    assign bus.o_ERR        = err_q;
endmodule

// File: tb/tb_bubble_access_sequencer.sv
// Directed bench: table of SEEK/illegal commands plus hand-written READ, WRITE,
// write-underrun and reset-abort sequences, all with hand-derived expectations.
module tb_bubble_access_sequencer;
    localparam int AW = 12;

    logic clk = 1'b0, rst = 1'b1, tick = 1'b0, sense = 1'b0;
    logic bss_n, bsen_n, repen_n, swapen_n, wrdata_n;

    bubble_access_sequencer_if #(.AW(AW)) bus ();

    bubble_access_sequencer #(
        .LOOP_LEN(2053), .AW(AW), .PAGE_BITS(64), .DETECT_LAT(4), .BSS_CYCLES(16)
    ) dut (
        .i_EMUCLK(clk), .i_RST(rst), .i_ROT_TICK(tick), .i_SENSE(sense),
        .o_BSS_n(bss_n), .o_BSEN_n(bsen_n), .o_REPEN_n(repen_n),
        .o_SWAPEN_n(swapen_n), .o_WRDATA_n(wrdata_n), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cmd;
        int page;
        int err;
        int done;
        int bss;
        int bsen;
        int pos;
    } vec_t;

    int checks = 0, errors = 0;
    int n_err, n_done, n_bss, n_bsen, n_rep, n_swap, swap_pos, err_tick;
    int tick_no = 0, last_tick = -1, start_tick = 0;
    logic wr_hist[$];
    int   rv_tick[$];
    logic rv_bit[$];
    bit          host_on = 1'b0;
    int          widx = 0, wlimit = 0;
    logic [63:0] wbits = 64'hA5C3_0F1E_96D2_7B48;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic sense_of(input int n);
        return ((n % 3) == 0) ^ ((n % 7) == 2);
    endfunction

    // One clock: observe mid-cycle values, cross the edge, observe registered results.
    task automatic cyc();
        logic fire;
        fire = bus.i_WBIT_VALID && bus.o_WBIT_READY;
        if (!bss_n) n_bss++;
        if (tick) begin
            last_tick = tick_no;
            tick_no++;
            wr_hist.push_back(wrdata_n);
            if (!bsen_n) n_bsen++;
            if (!repen_n) n_rep++;
            if (!swapen_n) begin
                n_swap++;
                swap_pos = int'(bus.o_POS);
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (fire) widx++;
        if (bus.o_ERR) begin
            n_err++;
            err_tick = last_tick;
        end
        if (bus.o_DONE) n_done++;
        if (bus.o_RBIT_VALID) begin
            rv_tick.push_back(last_tick);
            rv_bit.push_back(bus.o_RBIT);
        end
        bus.i_WBIT_VALID = host_on && (widx < wlimit);
        bus.i_WBIT       = wbits[widx[5:0]];
    endtask

    task automatic rot();
        tick  = 1'b1;
        sense = sense_of(tick_no);
        cyc();
        tick  = 1'b0;
        sense = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic clr();
        n_err = 0; n_done = 0; n_bss = 0; n_bsen = 0; n_rep = 0; n_swap = 0;
        swap_pos = -1; err_tick = -1;
        rv_tick.delete();
        rv_bit.delete();
    endtask

    task automatic start_cmd(input logic [1:0] c, input int page);
        clr();
        chk("ready_before_cmd", bus.o_CMD_READY, 1);
        bus.i_CMD_VALID = 1'b1;
        bus.i_CMD       = c;
        bus.i_PAGE      = AW'(page);
        cyc();
        bus.i_CMD_VALID = 1'b0;
        for (int i = 0; i < 40 && bus.o_BUSY && bsen_n; i++) cyc();
        start_tick = tick_no;
    endtask

    task automatic run_ticks(input string name);
        int i;
        i = 0;
        while (bus.o_BUSY && i < 2400) begin
            rot();
            i++;
        end
        chk({name, "_terminates"}, bus.o_BUSY, 0);
        cyc();
        cyc();
    endtask

    vec_t vecs[8];
    int   mism, ws, rs;

    initial begin
        bus.i_CMD_VALID  = 1'b0;
        bus.i_CMD        = 2'b00;
        bus.i_PAGE       = '0;
        bus.i_WBIT       = 1'b0;
        bus.i_WBIT_VALID = 1'b0;
        vecs[0] = '{2'b00,    5, 1, 0,  0,    0,    0};
        vecs[1] = '{2'b01, 2053, 1, 0,  0,    0,    0};
        vecs[2] = '{2'b10, 4095, 1, 0,  0,    0,    0};
        vecs[3] = '{2'b01,    5, 0, 1, 16,    6,    5};
        vecs[4] = '{2'b01,    5, 0, 1,  0,    0,    5};
        vecs[5] = '{2'b01, 2050, 0, 1, 16, 2046, 2050};
        vecs[6] = '{2'b01,    3, 0, 1, 16,    7,    3};
        vecs[7] = '{2'b01,    0, 0, 1, 16, 2051,    0};
        clr();

        @(negedge clk);
        repeat (3) cyc();
        chk("rst_bss_n", bss_n, 1);
        chk("rst_bsen_n", bsen_n, 1);
        chk("rst_repen_n", repen_n, 1);
        chk("rst_swapen_n", swapen_n, 1);
        chk("rst_wrdata_n", wrdata_n, 1);
        chk("rst_rbit", bus.o_RBIT, 0);
        chk("rst_rbit_valid", bus.o_RBIT_VALID, 0);
        chk("rst_done", bus.o_DONE, 0);
        chk("rst_err", bus.o_ERR, 0);
        chk("rst_busy", bus.o_BUSY, 0);
        chk("rst_ready", bus.o_CMD_READY, 1);
        chk("rst_pos", bus.o_POS, 0);
        chk("rst_wbit_ready", bus.o_WBIT_READY, 0);
        rst = 1'b0;
        cyc();

        for (int v = 0; v < 8; v++) begin
            start_cmd(vecs[v].cmd, vecs[v].page);
            run_ticks($sformatf("v%0d", v));
            chk($sformatf("v%0d_err", v), n_err, vecs[v].err);
            chk($sformatf("v%0d_done", v), n_done, vecs[v].done);
            chk($sformatf("v%0d_bss_cycles", v), n_bss, vecs[v].bss);
            chk($sformatf("v%0d_bsen_ticks", v), n_bsen, vecs[v].bsen);
            chk($sformatf("v%0d_pos", v), bus.o_POS, vecs[v].pos);
        end

        // READ page 0 from pos 0: replicate on the very first rotation.
        start_cmd(2'b10, 0);
        rs = start_tick;
        run_ticks("read");
        chk("read_repen_rotations", n_rep, 64);
        chk("read_strobes", rv_tick.size(), 64);
        chk("read_first_strobe_tick", (rv_tick.size() > 0) ? rv_tick[0] : -1, rs + 4);
        mism = 0;
        foreach (rv_tick[k])
            if (rv_tick[k] != rs + 4 + k || rv_bit[k] !== sense_of(rs + 4 + k)) mism++;
        chk("read_data_mismatches", mism, 0);
        chk("read_done", n_done, 1);
        chk("read_err", n_err, 0);
        chk("read_final_pos", bus.o_POS, 67);

        // WRITE page 10 from pos 67: generate at 67..130, align around the loop, swap at 10.
        host_on = 1'b1; widx = 0; wlimit = 64;
        start_cmd(2'b11, 10);
        ws = start_tick;
        run_ticks("write");
        host_on = 1'b0;
        bus.i_WBIT_VALID = 1'b0;
        chk("write_bits_taken", widx, 64);
        chk("write_swap_count", n_swap, 1);
        chk("write_swap_pos", swap_pos, 10);
        mism = 0;
        if (wr_hist[ws] !== 1'b1) mism++;
        for (int k = 0; k < 64; k++) if (wr_hist[ws + 1 + k] !== ~wbits[k]) mism++;
        if (wr_hist[ws + 65] !== 1'b1) mism++;
        chk("write_wrdata_mismatches", mism, 0);
        chk("write_done", n_done, 1);
        chk("write_err", n_err, 0);
        chk("write_final_pos", bus.o_POS, 11);

        // WRITE page 20 with host stalling before bit 20: underrun on rotation 20.
        host_on = 1'b1; widx = 0; wlimit = 20;
        start_cmd(2'b11, 20);
        ws = start_tick;
        run_ticks("underrun");
        host_on = 1'b0;
        bus.i_WBIT_VALID = 1'b0;
        chk("underrun_err", n_err, 1);
        chk("underrun_err_tick", err_tick, ws + 20);
        chk("underrun_done", n_done, 0);
        chk("underrun_swap", n_swap, 0);
        chk("underrun_bsen_ticks", n_bsen, 21);
        mism = 0;
        for (int k = 0; k < 20; k++) if (wr_hist[ws + 1 + k] !== ~wbits[k]) mism++;
        chk("underrun_wrdata_mismatches", mism, 0);
        chk("underrun_wrdata_idle", wr_hist[ws + 21], 1);
        chk("underrun_final_pos", bus.o_POS, 31);
        chk("idle_wbit_ready", bus.o_WBIT_READY, 0);

        // Reset in the middle of a READ replicate window.
        rst = 1'b1; cyc(); rst = 1'b0; cyc();
        chk("pre_read_pos", bus.o_POS, 0);
        start_cmd(2'b10, 0);
        repeat (10) rot();
        chk("abort_in_repl", repen_n, 0);
        rst = 1'b1;
        cyc();
        chk("abort_bss_n", bss_n, 1);
        chk("abort_bsen_n", bsen_n, 1);
        chk("abort_repen_n", repen_n, 1);
        chk("abort_swapen_n", swapen_n, 1);
        chk("abort_wrdata_n", wrdata_n, 1);
        chk("abort_pos", bus.o_POS, 0);
        chk("abort_ready", bus.o_CMD_READY, 1);
        chk("abort_busy", bus.o_BUSY, 0);
        rst = 1'b0;
        clr();
        repeat (4) cyc();
        chk("abort_no_done", n_done, 0);
        chk("abort_no_err", n_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
